ssd_display_ctrl: RTL and testbench
===================================

Name: ssd_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller for the board debug display. It is the successor of the fixed 4-digit hex driver. It captures a binary value on a load strobe and renders it in hex or decimal. Decimal mode adds signed display, leading-zero blanking and overflow indication. All digits are time-multiplexed from one clock. It sits beside the processor core and takes the debug-mux value (PC, register data, ALU result, and so on) as data_in.

Parameters:
NUM_DIGITS, 4, number of digit positions and anode lines (2..8)
DATA_W, 16, width of data_in (4..32)
REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2)
ACTIVE_LOW, 1, 1 = seg and anode outputs are active-low; 0 = active-high

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
load  in  1  single-cycle strobe; capture data_in and mode bits
data_in  in  DATA_W  value to display
mode_dec  in  1  0 = hex, 1 = decimal
signed_en  in  1  decimal only: treat data_in as two's complement
blank_lz  in  1  blank leading zeros (digit 0 never blanked)
busy  out  1  decimal conversion in progress
overflow  out  1  displayed value did not fit; sticky until next accepted load
anode  out  NUM_DIGITS  one-hot digit enable
seg  out  7  segments {g,f,e,d,c,b,a}

Behaviour:
- Reset (async, reset=0): all anodes off, seg all off, busy=0, overflow=0, display buffer = all blank, refresh counter=0, digit index=0.
- The display buffer holds NUM_DIGITS symbols (0-F, blank, dash). The scan logic reads only the buffer, so the old value stays shown until a new one commits.
- load is accepted only when busy=0. A load during busy is ignored, with no state change.
- Hex mode: the buffer is updated at the accepting edge and busy never asserts. Digit i shows nibble i; nibbles beyond DATA_W are 0. signed_en is ignored. blank_lz applies. overflow=1 if any data_in bits above 4*NUM_DIGITS are nonzero; the low digits are still shown.
- Decimal mode: sequential double-dabble, one bit per cycle.
  - busy rises at the accepting edge and stays high exactly DATA_W+1 cycles: DATA_W shift cycles plus 1 commit cycle.
  - The buffer and overflow update at the edge where busy falls.
  - signed_en=1 with an MSB of 1 converts the magnitude. -2^(DATA_W-1) must be handled correctly.
- Sign placement:
  - With blank_lz=0, '-' occupies digit NUM_DIGITS-1.
  - With blank_lz=1, '-' sits immediately left of the most significant displayed digit.
- Overflow (decimal): set when the magnitude exceeds 10^NUM_DIGITS-1 for a non-negative value, or 10^(NUM_DIGITS-1)-1 for a negative value. On overflow every digit shows a dash.
- Segment encoding:
  - Standard hex glyphs, with b and d lowercase.
  - Dash = g only. Blank = all segments off.
  - ACTIVE_LOW inverts both seg and anode.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. At wrap, the digit index increments, wrapping at NUM_DIGITS-1 to 0.
  - Exactly one anode is active at a time after the first clock out of reset.
  - anode and seg are registered and change on the same edge, so there is no ghosting between digits.
- Reset mid-conversion: busy is cleared, the conversion is abandoned, and the buffer is blanked.
- A load on the same edge that busy falls is ignored. The next cycle may load.

Test Plan:
All scenarios use defaults except REFRESH_DIV=4, with ACTIVE_LOW=1.
1. Reset asserted, then released -> anode=4'b1111 and seg=7'h7F during reset; busy=0; after release, anode steps 1110,1101,1011,0111,1110 every 4 cycles.
2. Hex: load 16'hBEEF, mode_dec=0 -> busy stays 0; digits 3..0 show B,E,E,F; digit 0 seg=7'h0E; overflow=0.
3. Decimal: load 16'd1234 -> busy high exactly 17 cycles; digits 1,2,3,4. Then load 16'd42 with blank_lz=1 -> digits blank,blank,4,2.
4. Signed: load 16'hFFF9, mode_dec=1, signed_en=1, blank_lz=1 -> digits blank,blank,-,7. Load 16'hFC18 (-1000) -> overflow=1, all digits dash. Load 16'd12345 unsigned -> overflow=1.
5. Load 16'd9999 then pulse load with 16'd1 at cycle 5 of busy -> second load ignored; display 9,9,9,9. Assert reset at cycle 8 of a new conversion -> busy=0 immediately; buffer blank.
6. Generic NUM_DIGITS=6, DATA_W=32: load 32'd999999 decimal -> 999999 shown, busy 33 cycles. Load 32'd1000000 -> overflow=1.

Source files
------------

// File: rtl/ssd_display_ctrl.sv
// Multi-digit seven-segment display controller: captures a value on load and shows it
// in hex or decimal (signed, leading-zero blanking, overflow dashes), time-multiplexed.
module ssd_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  mode_dec,
    input  logic                  signed_en,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);

    localparam int HEX_W    = 4 * NUM_DIGITS;
    localparam int BCD_CALC = (DATA_W * 3) / 10 + 2;
    localparam int BCD_D    = (BCD_CALC > NUM_DIGITS) ? BCD_CALC : NUM_DIGITS;
    localparam int BCD_W    = 4 * BCD_D;
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int CNT_W    = $clog2(REFRESH_DIV);
    localparam int BIT_W    = $clog2(DATA_W + 1);
    localparam bit AL       = (ACTIVE_LOW != 0);

    localparam logic [4:0] SYM_BLANK = 5'd16;
    localparam logic [4:0] SYM_DASH  = 5'd17;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AL}};
    localparam logic [6:0]            SEG_OFF = {7{AL}};

    function automatic logic [6:0] glyph(input logic [4:0] s);
        case (s)
            5'd0:     return 7'h3F;
            5'd1:     return 7'h06;
            5'd2:     return 7'h5B;
            5'd3:     return 7'h4F;
            5'd4:     return 7'h66;
            5'd5:     return 7'h6D;
            5'd6:     return 7'h7D;
            5'd7:     return 7'h07;
            5'd8:     return 7'h7F;
            5'd9:     return 7'h6F;
            5'd10:    return 7'h77;
            5'd11:    return 7'h7C;
            5'd12:    return 7'h39;
            5'd13:    return 7'h5E;
            5'd14:    return 7'h79;
            5'd15:    return 7'h71;
            SYM_DASH: return 7'h40;
            default:  return 7'h00;
        endcase
    endfunction

    logic [4:0]              buf_q [NUM_DIGITS];
    logic                    busy_q;
    logic                    ovf_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic [6:0]              seg_q;

    logic [DATA_W-1:0]       sr_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    neg_q;
    logic                    blz_q;

    logic                    accept;
    logic                    is_neg;
    logic [DATA_W-1:0]       mag;
    logic [HEX_W+DATA_W-1:0] data_ext;
    logic [4:0]              hex_sym [NUM_DIGITS];
    logic                    hex_ovf;
    logic                    hex_lead;
    logic [BCD_W-1:0]        bcd_adj;
    logic [4:0]              dec_sym [NUM_DIGITS];
    logic                    dec_ovf;
    logic                    dec_lead;
    logic                    dash_done;
    logic [NUM_DIGITS-1:0]   scan_onehot;

    assign accept      = load && !busy_q;
    assign is_neg      = signed_en && data_in[DATA_W-1];
    assign mag         = is_neg ? -data_in : data_in;
    assign scan_onehot = NUM_DIGITS'(1) << idx_q;

    // Hex symbols straight from the input so they can commit on the accepting edge.
    always_comb begin
        data_ext = {{HEX_W{1'b0}}, data_in};
        hex_ovf  = |data_ext[HEX_W+DATA_W-1:HEX_W];
        hex_lead = blank_lz;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_sym[i] = {1'b0, data_ext[4*i +: 4]};
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (hex_lead && data_ext[4*i +: 4] == 4'd0) hex_sym[i] = SYM_BLANK;
            else                                        hex_lead  = 1'b0;
        end
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_D; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    // A negative value reserves one digit for the sign, so it overflows one decade earlier.
    always_comb begin
        dec_ovf   = 1'b0;
        dec_lead  = blz_q;
        dash_done = 1'b0;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0 &&
                (i >= NUM_DIGITS || (neg_q && i >= NUM_DIGITS - 1))) dec_ovf = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dec_sym[i] = {1'b0, bcd_q[4*i +: 4]};
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (dec_lead && bcd_q[4*i +: 4] == 4'd0) dec_sym[i] = SYM_BLANK;
            else                                     dec_lead   = 1'b0;
        end
        if (neg_q) begin
            if (!blz_q) begin
                dec_sym[NUM_DIGITS-1] = SYM_DASH;
            end else begin
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    if (!dash_done && dec_sym[i] == SYM_BLANK) begin
                        dec_sym[i] = SYM_DASH;
                        dash_done  = 1'b1;
                    end
                end
            end
        end
        if (dec_ovf) begin
            for (int i = 0; i < NUM_DIGITS; i++) dec_sym[i] = SYM_DASH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bit_cnt_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= SYM_BLANK;
        end else if (busy_q) begin
            if (bit_cnt_q == BIT_W'(DATA_W)) begin
                busy_q <= 1'b0;
                ovf_q  <= dec_ovf;
                for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= dec_sym[i];
            end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
        end else if (accept) begin
            if (mode_dec) begin
                busy_q    <= 1'b1;
                bit_cnt_q <= '0;
            end else begin
                ovf_q <= hex_ovf;
                for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= hex_sym[i];
            end
        end
    end

    // Double-dabble datapath: one add-3 then shift per busy cycle, commit cycle excluded.
    always_ff @(posedge clk) begin
        if (accept && mode_dec) begin
            sr_q  <= mag;
            bcd_q <= '0;
            neg_q <= is_neg;
            blz_q <= blank_lz;
        end else if (busy_q && bit_cnt_q != BIT_W'(DATA_W)) begin
            sr_q  <= sr_q << 1;
            bcd_q <= {bcd_adj[BCD_W-2:0], sr_q[DATA_W-1]};
        end
    end

    // Scan stage: anode and seg registered together from the same digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= AN_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            anode_q <= AL ? ~scan_onehot : scan_onehot;
            seg_q   <= AL ? ~glyph(buf_q[idx_q]) : glyph(buf_q[idx_q]);
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign anode    = anode_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl: a 4-digit/16-bit and a 6-digit/32-bit instance,
// both with REFRESH_DIV=4 and active-low outputs.
module tb_ssd_display_ctrl;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S7 = 7'h78, S9 = 7'h10, SB = 7'h03, SE = 7'h06, SF = 7'h0E;
    localparam logic [6:0] DASH = 7'h3F, BLANK = 7'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_a, load_b;
    logic [15:0] data_a;
    logic [31:0] data_b;
    logic        mode_dec, signed_en, blank_lz;
    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [3:0]  anode_a;
    logic [5:0]  anode_b;
    logic [6:0]  seg_a, seg_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ssd_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset(reset), .load(load_a), .data_in(data_a), .mode_dec(mode_dec),
        .signed_en(signed_en), .blank_lz(blank_lz), .busy(busy_a), .overflow(ovf_a),
        .anode(anode_a), .seg(seg_a));

    ssd_display_ctrl #(.NUM_DIGITS(6), .DATA_W(32), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .data_in(data_b), .mode_dec(mode_dec),
        .signed_en(signed_en), .blank_lz(blank_lz), .busy(busy_b), .overflow(ovf_b),
        .anode(anode_b), .seg(seg_b));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic read_dig(input bit sel_b, input int d, output logic [6:0] s);
        bit found = 1'b0;
        s = 7'h00;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (sel_b ? (anode_b == ~(6'b000001 << d)) : (anode_a == ~(4'b0001 << d))) begin
                found = 1'b1;
                s     = sel_b ? seg_b : seg_a;
            end
        end
        check($sformatf("scan_found_d%0d", d), found, 1'b1);
    endtask

    task automatic chk_dig(input bit sel_b, input int d, input logic [6:0] exp, input string tag);
        logic [6:0] s;
        read_dig(sel_b, d, s);
        check($sformatf("%s_d%0d", tag, d), s, exp);
    endtask

    task automatic run_load(input bit sel_b, input logic [31:0] val, input bit dec, input bit sgn,
                            input bit blz, input int pulse_at, input logic [31:0] pval,
                            input bit pdec, output int busy_cycles);
        bit pulsed;
        @(negedge clk);
        mode_dec  = dec;
        signed_en = sgn;
        blank_lz  = blz;
        if (sel_b) begin data_b = val;        load_b = 1'b1; end
        else       begin data_a = val[15:0];  load_a = 1'b1; end
        pulsed      = 1'b1;
        busy_cycles = 0;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pulsed) begin load_a = 1'b0; load_b = 1'b0; pulsed = 1'b0; end
            if (!(sel_b ? busy_b : busy_a)) break;
            busy_cycles++;
            if (busy_cycles == pulse_at) begin
                mode_dec = pdec;
                if (sel_b) begin data_b = pval;        load_b = 1'b1; end
                else       begin data_a = pval[15:0];  load_a = 1'b1; end
                pulsed = 1'b1;
            end
        end
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [3:0] an_seq [5];
        an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        reset = 1'b1; load_a = 1'b0; load_b = 1'b0; data_a = '0; data_b = '0;
        mode_dec = 1'b0; signed_en = 1'b0; blank_lz = 1'b0;

        // Reset state and scan order
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_anode_a", anode_a, 4'hF);
        check("rst_seg_a", seg_a, BLANK);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_ovf_a", ovf_a, 1'b0);
        check("rst_anode_b", anode_b, 6'h3F);
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j == 0) @(negedge clk);
            else        repeat (4) @(negedge clk);
            check($sformatf("scan_step%0d", j), anode_a, an_seq[j]);
        end
        check("scan_seg_blank", seg_a, BLANK);

        // Hex
        run_load(1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0, -1, '0, 1'b0, bc);
        check("hex_busy_cycles", bc, 0);
        check("hex_ovf", ovf_a, 1'b0);
        chk_dig(1'b0, 3, SB, "hex"); chk_dig(1'b0, 2, SE, "hex");
        chk_dig(1'b0, 1, SE, "hex"); chk_dig(1'b0, 0, SF, "hex");

        // Decimal
        run_load(1'b0, 32'd1234, 1'b1, 1'b0, 1'b0, -1, '0, 1'b0, bc);
        check("dec1234_busy", bc, 17);
        check("dec1234_ovf", ovf_a, 1'b0);
        chk_dig(1'b0, 3, S1, "dec1234"); chk_dig(1'b0, 2, S2, "dec1234");
        chk_dig(1'b0, 1, S3, "dec1234"); chk_dig(1'b0, 0, S4, "dec1234");
        run_load(1'b0, 32'd42, 1'b1, 1'b0, 1'b1, -1, '0, 1'b0, bc);
        chk_dig(1'b0, 3, BLANK, "dec42"); chk_dig(1'b0, 2, BLANK, "dec42");
        chk_dig(1'b0, 1, S4, "dec42");    chk_dig(1'b0, 0, S2, "dec42");

        // Load on the falling-busy edge is ignored
        run_load(1'b0, 32'd1234, 1'b1, 1'b0, 1'b0, 17, 32'h00AB, 1'b0, bc);
        check("fall_load_busy", bc, 17);
        @(negedge clk);
        check("fall_load_busy_after", busy_a, 1'b0);
        chk_dig(1'b0, 0, S4, "fall_load"); chk_dig(1'b0, 1, S3, "fall_load");

        // Signed
        run_load(1'b0, 32'hFFF9, 1'b1, 1'b1, 1'b1, -1, '0, 1'b1, bc);
        check("neg7_busy", bc, 17);
        check("neg7_ovf", ovf_a, 1'b0);
        chk_dig(1'b0, 3, BLANK, "neg7lz"); chk_dig(1'b0, 2, BLANK, "neg7lz");
        chk_dig(1'b0, 1, DASH, "neg7lz");  chk_dig(1'b0, 0, S7, "neg7lz");
        run_load(1'b0, 32'hFFF9, 1'b1, 1'b1, 1'b0, -1, '0, 1'b1, bc);
        chk_dig(1'b0, 3, DASH, "neg7"); chk_dig(1'b0, 2, S0, "neg7");
        chk_dig(1'b0, 1, S0, "neg7");   chk_dig(1'b0, 0, S7, "neg7");
        run_load(1'b0, 32'hFC18, 1'b1, 1'b1, 1'b1, -1, '0, 1'b1, bc);
        check("neg1000_ovf", ovf_a, 1'b1);
        chk_dig(1'b0, 0, DASH, "neg1000"); chk_dig(1'b0, 3, DASH, "neg1000");
        run_load(1'b0, 32'd12345, 1'b1, 1'b0, 1'b0, -1, '0, 1'b1, bc);
        check("u12345_ovf", ovf_a, 1'b1);
        chk_dig(1'b0, 2, DASH, "u12345");
        run_load(1'b0, 32'h8000, 1'b1, 1'b1, 1'b0, -1, '0, 1'b1, bc);
        check("min_neg_busy", bc, 17);
        check("min_neg_ovf", ovf_a, 1'b1);

        // Load during busy is ignored
        run_load(1'b0, 32'd9999, 1'b1, 1'b0, 1'b0, 5, 32'd1, 1'b1, bc);
        check("busy_load_cycles", bc, 17);
        check("busy_load_ovf", ovf_a, 1'b0);
        for (int d = 0; d < 4; d++) chk_dig(1'b0, d, S9, "dec9999");

        // Reset mid-conversion
        @(negedge clk);
        mode_dec = 1'b1; signed_en = 1'b0; blank_lz = 1'b0; data_a = 16'd1234; load_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            load_a = 1'b0;
        end
        check("mid_busy_before", busy_a, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_anode", anode_a, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        chk_dig(1'b0, 0, BLANK, "mid_rst"); chk_dig(1'b0, 3, BLANK, "mid_rst");
        check("mid_rst_ovf", ovf_a, 1'b0);

        // Six digits, 32-bit
        run_load(1'b1, 32'd999999, 1'b1, 1'b0, 1'b0, -1, '0, 1'b1, bc);
        check("b999999_busy", bc, 33);
        check("b999999_ovf", ovf_b, 1'b0);
        for (int d = 0; d < 6; d++) chk_dig(1'b1, d, S9, "b999999");
        run_load(1'b1, 32'd1000000, 1'b1, 1'b0, 1'b0, -1, '0, 1'b1, bc);
        check("b1000000_busy", bc, 33);
        check("b1000000_ovf", ovf_b, 1'b1);
        chk_dig(1'b1, 0, DASH, "b1000000");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
